// File: rtl/dmem_xfer_ctrl.sv
// Sequencer that swaps or copies word ranges through a dual-port byte memory,
// one READ / WRITE / SETTLE triple per word, behind a start/busy/done handshake.
module dmem_xfer_ctrl #(
  parameter int MEM_BYTES = 64,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_cnt,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      Address1,
  output logic [31:0]      Address2,
  output logic [31:0]      WriteData1,
  output logic [31:0]      WriteData2,
  output logic             MemRead,
  output logic             MemWrite,
  input  logic [31:0]      Data1,
  input  logic [31:0]      Data2
);

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_READ   = 6'b000010,
    S_WRITE  = 6'b000100,
    S_SETTLE = 6'b001000,
    S_DONE   = 6'b010000,
    S_ERR    = 6'b100000
  } state_t;

  state_t             state_q, state_d;
  logic               op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr1_q, addr1_d, addr2_q, addr2_d;
  logic [31:0]        wd1_q, wd1_d, wd2_q, wd2_d;

  // Bounds and overlap test done in 33 bits so address + span cannot wrap.
  function automatic logic req_bad(input logic [31:0] s, input logic [31:0] d,
                                   input logic [CNT_W-1:0] n);
    logic [32:0] span, s_end, d_end;
    span  = 33'(n) << 2;
    s_end = {1'b0, s} + span;
    d_end = {1'b0, d} + span;
    req_bad = (s_end > 33'(MEM_BYTES)) || (d_end > 33'(MEM_BYTES)) ||
              ((n != '0) && ({1'b0, s} < d_end) && ({1'b0, d} < s_end));
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    wd1_d   = wd1_q;
    wd2_d   = wd2_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (req_bad(src_addr, dst_addr, word_cnt)) begin
            state_d = S_ERR;
          end else if (word_cnt == '0) begin
            state_d = S_DONE;
          end else begin
            op_d    = op;
            cnt_d   = word_cnt;
            addr1_d = src_addr;
            addr2_d = dst_addr;
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        // Write data is captured here so it is stable before MemWrite rises.
        wd1_d   = op_q ? Data1 : Data2;
        wd2_d   = Data1;
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_SETTLE;
      S_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end else begin
          addr1_d = addr1_q + 32'd4;
          addr2_d = addr2_q + 32'd4;
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      cnt_q   <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
      wd1_q   <= '0;
      wd2_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      wd1_q   <= wd1_d;
      wd2_q   <= wd2_d;
    end
  end

  // Strobes come straight off single state flops, so they cannot glitch.
  assign MemRead    = state_q[1];
  assign MemWrite   = state_q[2];
  assign busy       = state_q[1] | state_q[2] | state_q[3];
  assign done       = state_q[4];
  assign err        = state_q[5];
  assign Address1   = addr1_q;
  assign Address2   = addr2_q;
  assign WriteData1 = wd1_q;
  assign WriteData2 = wd2_q;

endmodule

// File: tb/tb_dmem_xfer_ctrl.sv
// Bench for dmem_xfer_ctrl: byte-array memory model plus directed table,
// reset-mid-operation sequence and randomized requests against a reference model.
module tb_dmem_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op_i;
  logic [31:0] src_i, dst_i;
  logic [3:0]  cnt_i;
  logic        busy, done, err, MemRead, MemWrite;
  logic [31:0] Address1, Address2, WriteData1, WriteData2, Data1, Data2;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem      [64];
  logic [7:0] ref_mem  [64];
  logic [7:0] load_img [64];
  logic       load_req = 1'b0;

  always #5 clk = ~clk;

  dmem_xfer_ctrl #(.MEM_BYTES(64), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op_i),
    .src_addr(src_i), .dst_addr(dst_i), .word_cnt(cnt_i),
    .busy(busy), .done(done), .err(err),
    .Address1(Address1), .Address2(Address2),
    .WriteData1(WriteData1), .WriteData2(WriteData2),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .Data1(Data1), .Data2(Data2)
  );

  // Big-endian combinational read ports.
  assign Data1 = {mem[Address1[5:0]], mem[6'(Address1[5:0] + 6'd1)],
                  mem[6'(Address1[5:0] + 6'd2)], mem[6'(Address1[5:0] + 6'd3)]};
  assign Data2 = {mem[Address2[5:0]], mem[6'(Address2[5:0] + 6'd1)],
                  mem[6'(Address2[5:0] + 6'd2)], mem[6'(Address2[5:0] + 6'd3)]};

  // Write lands mid-cycle while MemWrite is high; reset drops it before this edge.
  always @(negedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= load_img[i];
    end else if (MemWrite) begin
      for (int k = 0; k < 4; k++) begin
        mem[6'(Address1[5:0] + 6'(k))] <= WriteData1[31-8*k -: 8];
        mem[6'(Address2[5:0] + 6'(k))] <= WriteData2[31-8*k -: 8];
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic load_mem();
    load_req = 1'b1;
    @(negedge clk);
    #1 load_req = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = load_img[i];
  endtask

  function automatic logic [31:0] mw(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  // Reference rules in plain integer arithmetic.
  function automatic bit m_reject(input longint s, input longint d, input longint n);
    return (s + 4*n > 64) || (d + 4*n > 64) || (n > 0 && s < d + 4*n && d < s + 4*n);
  endfunction

  function automatic void m_apply(input bit o, input int s, input int d, input int nbytes);
    logic [7:0] t;
    for (int i = 0; i < nbytes; i++) begin
      if (o) ref_mem[d+i] = ref_mem[s+i];
      else begin
        t = ref_mem[s+i]; ref_mem[s+i] = ref_mem[d+i]; ref_mem[d+i] = t;
      end
    end
  endfunction

  task automatic mem_cmp(input string nm);
    int diff = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk({nm, "_mem"}, diff, 0);
  endtask

  // Issue one request and check every cycle of strobes against the latency rules.
  task automatic run_op(input bit o, input logic [31:0] s, input logic [31:0] d,
                        input int n, input int rp, input bit exp_err,
                        input int exp_cyc, input string nm);
    int  seq_bad = 0;
    int  ev = -1;
    int  both = 0;
    bit  acc = !exp_err && (n > 0);
    bit  e_rd, e_wr, e_busy, e_done, e_err;
    op_i = o; src_i = s; dst_i = d; cnt_i = 4'(n); start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= exp_cyc + 2; c++) begin
      op_i = 1'($urandom); src_i = $urandom; dst_i = $urandom; cnt_i = 4'($urandom);
      start  = (c == rp);
      e_rd   = acc && c <= 3*n && (c % 3 == 1);
      e_wr   = acc && c <= 3*n && (c % 3 == 2);
      e_busy = acc && c <= 3*n;
      e_done = !exp_err && c == exp_cyc;
      e_err  = exp_err && c == 1;
      if ({MemRead, MemWrite, busy, done, err} !== {e_rd, e_wr, e_busy, e_done, e_err})
        seq_bad++;
      if (MemRead && MemWrite) both++;
      if (ev < 0 && (done || err)) ev = c;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk({nm, "_event_cycle"}, ev, exp_cyc);
    chk({nm, "_strobes"}, seq_bad + both, 0);
    if (!exp_err) m_apply(o, int'(s), int'(d), 4*n);
    mem_cmp(nm);
  endtask

  typedef struct {
    bit          o;
    logic [31:0] s;
    logic [31:0] d;
    int          n;
    int          rp;
    bit          exp_err;
    int          exp_cyc;
    string       nm;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{0, 32'd0,  32'd8,  1, 0, 0, 4,  "swap1"};
    tbl[1] = '{1, 32'd12, 32'd40, 2, 0, 0, 7,  "copy2"};
    tbl[2] = '{0, 32'd0,  32'd4,  2, 0, 1, 1,  "overlap"};
    tbl[3] = '{1, 32'd60, 32'd0,  2, 0, 1, 1,  "src_oob"};
    tbl[4] = '{0, 32'd0,  32'd56, 3, 0, 1, 1,  "dst_oob"};
    tbl[5] = '{0, 32'd8,  32'd8,  1, 0, 1, 1,  "same_addr"};
    tbl[6] = '{1, 32'd0,  32'd0,  0, 0, 0, 1,  "cnt0"};
    tbl[7] = '{1, 32'd60, 32'd48, 1, 0, 0, 4,  "edge64"};
    tbl[8] = '{0, 32'hFFFF_FFFC, 32'd0, 1, 0, 1, 1, "wrap"};
    tbl[9] = '{0, 32'd16, 32'd28, 3, 2, 0, 10, "repulse"};

    rst_n = 1'b0; start = 1'b0; op_i = 1'b0; src_i = '0; dst_i = '0; cnt_i = '0;
    for (int i = 0; i < 64; i++) load_img[i] = 8'h00;
    {load_img[0], load_img[1], load_img[2], load_img[3]}     = 32'h0001_0203;
    {load_img[8], load_img[9], load_img[10], load_img[11]}   = 32'h0000_000C;
    {load_img[12], load_img[13], load_img[14], load_img[15]} = 32'h0C0D_0E0F;
    {load_img[16], load_img[17], load_img[18], load_img[19]} = 32'h1011_1213;
    load_mem();
    @(posedge clk); #1;
    chk("rst_ctrl", {busy, done, err, MemRead, MemWrite}, 0);
    chk("rst_data", Address1 | Address2 | WriteData1 | WriteData2, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_op(tbl[i].o, tbl[i].s, tbl[i].d, tbl[i].n, tbl[i].rp,
             tbl[i].exp_err, tbl[i].exp_cyc, tbl[i].nm);
    chk("word0",  mw(0),  32'h0000_000C);
    chk("word8",  mw(8),  32'h0001_0203);
    chk("word12", mw(12), 32'h0C0D_0E0F);
    chk("word40", mw(40), 32'h0C0D_0E0F);
    chk("word44", mw(44), 32'h1011_1213);

    // Reset during the second WRITE of a 3-word swap.
    op_i = 1'b0; src_i = 32'd0; dst_i = 32'd24; cnt_i = 4'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c < 5; c++) begin @(posedge clk); #1; end
    chk("rst_mid_wr_before", MemWrite, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", {busy, done, err, MemRead, MemWrite}, 0);
    chk("rst_mid_data", Address1 | Address2 | WriteData1 | WriteData2, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    m_apply(1'b0, 0, 24, 4);
    mem_cmp("rst_mid");
    run_op(1'b1, 32'd0, 32'd32, 1, 0, 0, 4, "after_rst");

    for (int i = 0; i < 64; i++) load_img[i] = 8'($urandom);
    load_mem();
    @(posedge clk); #1;
    for (int t = 0; t < 40; t++) begin
      bit  o = 1'($urandom);
      int  s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 70)) : 4 * int'($urandom_range(0, 16));
      int  d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 70)) : 4 * int'($urandom_range(0, 16));
      int  n = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 5));
      bit  rej = m_reject(s, d, n);
      int  cyc = (rej || n == 0) ? 1 : 3*n + 1;
      int  rp = (!rej && n > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(2, 3*n)) : 0;
      run_op(o, 32'(s), 32'(d), n, rp, rej, cyc, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_xfer_ctrl.md
Name: dmem_xfer_ctrl

Overview:
- Sequencer that sits directly upstream of the dual-port byte-addressed data memory.
- Drives the memory's Address1/Address2, WriteData1/WriteData2, MemRead and MemWrite, and consumes its Data1/Data2 read buses.
- Executes multi-word SWAP or COPY between two word ranges under a start/busy/done handshake.
- Replaces ad-hoc testbench poking of the memory and hides the memory's level-sensitive write timing from callers.

Parameters:
- MEM_BYTES, 64, memory size in bytes; every byte touched must be < MEM_BYTES.
- CNT_W, 4, width of word_cnt (max 15 words per operation).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse, sampled only in IDLE
- op  in  1  0 = SWAP, 1 = COPY (src to dst)
- src_addr  in  32  byte address of first source word
- dst_addr  in  32  byte address of first destination word
- word_cnt  in  CNT_W  number of 32-bit words
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle rejection pulse
- Address1  out  32  memory port 1 address (source side)
- Address2  out  32  memory port 2 address (destination side)
- WriteData1  out  32  memory port 1 write data
- WriteData2  out  32  memory port 2 write data
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable, both ports
- Data1  in  32  memory port 1 read data, big-endian word at Address1
- Data2  in  32  memory port 2 read data, big-endian word at Address2

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs are 0 and state is IDLE.
- Reset mid-operation:
  - MemWrite falls immediately and the FSM returns to IDLE.
  - Words whose WRITE completed stay written; no further writes occur.
- State register is one-hot: IDLE, READ, WRITE, SETTLE, DONE, ERR.
- MemRead is decoded directly from the READ flop; MemWrite directly from the WRITE flop. Both are glitch-free.
- Address and write-data outputs are registered.
- IDLE + start: the request is checked with 33-bit arithmetic, with n = word_cnt and span = 4n.
  - Reject if src_addr + span > MEM_BYTES.
  - Reject if dst_addr + span > MEM_BYTES.
  - Reject if n > 0 and the byte ranges [src, src+span) and [dst, dst+span) intersect. This includes src == dst.
  - Rejected request: go to ERR.
  - Otherwise, n == 0: go to DONE.
  - Otherwise: latch op and n, load Address1 = src_addr and Address2 = dst_addr, and go to READ.
- READ (1 cycle):
  - MemRead = 1.
  - On the closing edge, capture Data1 into r1 and Data2 into r2; go to WRITE.
- WRITE (1 cycle):
  - MemWrite = 1, addresses held.
  - SWAP: WriteData1 = r2, WriteData2 = r1.
  - COPY: WriteData1 = r1 (harmless rewrite), WriteData2 = r1.
  - Write data is loaded on the edge entering WRITE, so it is stable before MemWrite rises.
- SETTLE (1 cycle):
  - MemWrite = 0; addresses and write data are held, so the level-sensitive memory write closes cleanly.
  - Decrement the remaining count.
  - If the count is now 0, go to DONE.
  - Otherwise add 4 to both addresses and go to READ.
- DONE (1 cycle): done = 1, busy = 0, then IDLE.
- ERR (1 cycle): err = 1, no memory access, then IDLE.
- busy = 1 in READ, WRITE and SETTLE only.
- start outside IDLE is ignored; it is not queued.
- Latency from the edge that samples start:
  - n > 0: done is high in cycle 3n+1.
  - n = 0: done is high in cycle 1.
  - Rejected request: err is high in cycle 1.
- MemRead and MemWrite are never high in the same cycle.
- Inputs src_addr, dst_addr, op and word_cnt are don't-care after acceptance.

Test Plan:
- Memory image: word0 = 0x00010203, word8 = 0x0000000C, word12 = 0x0C0D0E0F, word16 = 0x10111213.
- SWAP src=0 dst=8 cnt=1 -> MemWrite high exactly cycle 2; done cycle 4; mem word0 = 0x0000000C, word8 = 0x00010203.
- COPY src=12 dst=40 cnt=2 -> done cycle 7; word40 = 0x0C0D0E0F, word44 = 0x10111213, sources unchanged; two MemWrite pulses, each bracketed by MemWrite = 0 cycles.
- SWAP src=0 dst=4 cnt=2 (overlap) -> err cycle 1, busy never high, no MemRead/MemWrite, memory unchanged.
- COPY src=60 dst=0 cnt=2 (60+8 > 64) -> err cycle 1. Separately, cnt=0 -> done cycle 1 with no memory access.
- SWAP cnt=3 with start re-pulsed in cycle 2 -> re-pulse ignored, single done at cycle 10.
- rst_n low during the second WRITE -> outputs 0 asynchronously; first word swapped; third word untouched; next start accepted normally.
